// File: rtl/div_iter_unit_pkg.sv
// Shared state encodings and sizing helpers for the iterative divider.
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_RUN  = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  function automatic int div_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_end_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic             neg_q, neg_r;

  logic             accept, a_neg, b_neg, div_zero, ovf, fast;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] step;

  // One restoring step: shift {rem,quo} left, keep the trial difference if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] shifted, trial;
    shifted = {r, q[WIDTH-1]};
    trial   = shifted - {1'b0, d};
    if (trial[WIDTH]) return {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    else              return {trial[WIDTH-1:0],   q[WIDTH-2:0], 1'b1};
  endfunction

  assign accept   = (state == DIV_ST_IDLE) & i_start & ~i_flush;
  assign a_neg    = i_signed & i_dividend[WIDTH-1];
  assign b_neg    = i_signed & i_divisor[WIDTH-1];
  assign a_mag    = a_neg ? -i_dividend : i_dividend;
  assign b_mag    = b_neg ? -i_divisor  : i_divisor;
  assign div_zero = (i_divisor == '0);
  assign ovf      = i_signed & (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&i_divisor);
  assign fast     = div_zero | ovf;
  assign step     = div_step(rem, quo, dsr);

  always_comb begin
    state_nxt   = state;
    o_busy      = accept | (state == DIV_ST_RUN) | (state == DIV_ST_FIX);
    o_end_valid = 1'b0;
    unique case (state)
      DIV_ST_IDLE: if (accept) state_nxt = fast ? DIV_ST_DONE : DIV_ST_RUN;
      DIV_ST_RUN: begin
        if (i_flush)         state_nxt = DIV_ST_IDLE;
        else if (cnt == '0)  state_nxt = DIV_ST_FIX;
      end
      DIV_ST_FIX:  state_nxt = i_flush ? DIV_ST_IDLE : DIV_ST_DONE;
      DIV_ST_DONE: begin
        // a start still asserted here belongs to the instruction just retired
        o_end_valid = ~i_flush;
        state_nxt   = DIV_ST_IDLE;
      end
      default:     state_nxt = DIV_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      if (accept) begin
        cnt   <= CNT_W'(WIDTH-1);
        rem   <= '0;
        quo   <= a_mag;
        dsr   <= b_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        if (fast) begin
          o_quotient  <= div_zero ? '1 : i_dividend;
          o_remainder <= div_zero ? i_dividend : '0;
        end
      end else if (state == DIV_ST_RUN && !i_flush) begin
        {rem, quo} <= step;
        cnt        <= cnt - CNT_W'(1);
      end else if (state == DIV_ST_FIX && !i_flush) begin
        o_quotient  <= neg_q ? (~quo + WIDTH'(1)) : quo;
        o_remainder <= neg_r ? (~rem + WIDTH'(1)) : rem;
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed corner cases plus randomized ops
// checked against a plain-arithmetic RV32M reference.
module tb_div_iter_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_flush = 1'b0, i_start = 1'b0, i_signed = 1'b0;
  logic [W-1:0] i_dividend = '0, i_divisor = '0;
  logic         o_busy, o_end_valid;
  logic [W-1:0] o_quotient, o_remainder;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_start(i_start),
    .i_signed(i_signed), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_busy(o_busy), .o_end_valid(o_end_valid),
    .o_quotient(o_quotient), .o_remainder(o_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0, errors = 0;
  int           cyc = 0;
  logic [W-1:0] last_q = '0, last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics with ordinary integer arithmetic (SV division truncates toward zero).
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    longint sa, sbv;
    lat = W + 2;
    if (b == 0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; lat = 1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q = W'(sa / sbv);
      r = W'(sa % sbv);
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Monitor: every end pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && o_end_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end_valid: got pulse q=%h r=%h want none (cycle %0d)",
                   o_quotient, o_remainder, cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", o_quotient, e.q);
          chk("remainder", o_remainder, e.r);
          chk("end_cycle", W'(cyc), W'(e.cyc));
        end
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit track, output int c0, output int lat);
    logic [W-1:0] q, r;
    @(negedge clk);
    i_dividend = a; i_divisor = b; i_signed = s; i_start = 1'b1;
    #1;
    chk("busy_accept", W'(o_busy), 1);
    model(a, b, s, q, r, lat);
    c0 = cyc;
    if (track) begin
      sb.push_back('{q, r, c0 + lat});
      last_q = q; last_r = r;
    end
  endtask

  // Hold start through completion (operands scrambled), then release it after DONE.
  task automatic finish_op(input int lat);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      i_dividend = $urandom; i_divisor = $urandom; i_signed = 1'($urandom);
      #1;
      if (k < lat) chk("busy_run", W'(o_busy), 1);
      else begin
        chk("busy_done", W'(o_busy), 0);
        chk("end_pulse", W'(o_end_valid), 1);
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    #1;
    chk("start_ignored_busy", W'(o_busy), 0);
    chk("end_single", W'(o_end_valid), 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int c0, lat;
    start_op(a, b, s, 1'b1, c0, lat);
    finish_op(lat);
  endtask

  initial begin
    int c0, lat;
    logic [W-1:0] a, b;
    // reset state, including combinational accept term while start is high
    #1;
    chk("rst_busy", W'(o_busy), 0);
    chk("rst_end", W'(o_end_valid), 0);
    chk("rst_q", o_quotient, 0);
    chk("rst_r", o_remainder, 0);
    i_start = 1'b1;
    #1;
    chk("rst_busy_start", W'(o_busy), 1);
    i_start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    do_op(32'd100, 32'd7, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    do_op(32'd5, 32'd0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1);

    // flush in RUN: no pulse, results hold, then a fresh op
    start_op(32'hFFFF_FFF0, 32'd3, 1'b0, 1'b0, c0, lat);
    repeat (10) @(negedge clk);
    i_flush = 1'b1; i_start = 1'b0;
    #1;
    chk("flush_end_low", W'(o_end_valid), 0);
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    chk("flush_busy", W'(o_busy), 0);
    chk("flush_hold_q", o_quotient, last_q);
    chk("flush_hold_r", o_remainder, last_r);
    repeat (40) @(negedge clk);
    do_op(32'd9, 32'd3, 1'b0);

    // flush and start together: never accepted
    @(negedge clk);
    i_dividend = 32'd50; i_divisor = 32'd5; i_start = 1'b1; i_flush = 1'b1;
    #1;
    chk("flush_start_busy", W'(o_busy), 0);
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    #1;
    chk("flush_start_no_accept", W'(o_busy), 0);

    // async reset mid-RUN
    start_op(32'd1000, 32'd7, 1'b0, 1'b0, c0, lat);
    repeat (5) @(negedge clk);
    i_start = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", W'(o_busy), 0);
    chk("midrst_end", W'(o_end_valid), 0);
    chk("midrst_q", o_quotient, 0);
    chk("midrst_r", o_remainder, 0);
    @(negedge clk);
    reset = 1'b0;
    last_q = '0; last_r = '0;
    do_op(32'd9, 32'd3, 1'b0);

    for (int n = 0; n < 24; n++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        3: b = W'($urandom_range(1, 255));
        default: ;
      endcase
      do_op(a, b, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
